// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: register offsets and channel count shared by the LED PWM controller
package led_pwm_pkg;
  localparam int NUM_CH = 8;
  localparam logic [7:0] OFS_EN = 8'd0;
  localparam logic [7:0] OFS_DUTY0 = 8'd1;
  localparam logic [7:0] OFS_BLINK = 8'd9;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel, active duty register, compare and output flop
// Ports: clk/rst (sync, active-high); load_i copies shadow_i into the active duty;
// en_i/blank_i gate the output; cnt_i is the shared period counter; led_o is registered.
module led_pwm_channel #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                en_i,
  input  logic                blank_i,
  input  logic [PWM_BITS-1:0] shadow_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  output logic                led_o
);
  logic [PWM_BITS-1:0] act_q;
  logic                led_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
      led_q <= 1'b0;
    end else begin
      if (load_i) act_q <= shadow_i;
      led_q <= en_i & ~blank_i & (cnt_i < act_q);
    end
  end
  assign led_o = led_q;
endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: PicoBlaze-mapped 8-channel LED PWM controller
// Ports: clk, rst (sync, active-high); port_id/out_port/write_strobe PicoBlaze write bus;
// led[7:0] registered LED drive. Optional blink register enabled by LED_PWM_CTRL_BLINK_EN.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         PWM_BITS  = 4,
  parameter int         PRESCALE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  output logic [7:0] led
);
  localparam int MAX = 2 ** PWM_BITS - 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_TOP = PWM_BITS'(MAX - 1);
  logic [PW-1:0]       pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]          en_q, en_d;
  logic [PWM_BITS-1:0] duty_q [NUM_CH];
  logic [PWM_BITS-1:0] duty_d [NUM_CH];
  logic [7:0]          ofs, blank;
  logic                tick, wrap;
  assign ofs  = port_id - BASE_ADDR;
  assign tick = pre_q == PRE_TOP;
  assign wrap = tick && cnt_q == CNT_TOP;
  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
    cnt_d = wrap ? '0 : cnt_q + PWM_BITS'(tick);
    en_d  = write_strobe && ofs == OFS_EN ? out_port : en_q;
    for (int i = 0; i < NUM_CH; i++)
      duty_d[i] = write_strobe && ofs == OFS_DUTY0 + 8'(i) ? out_port[PWM_BITS-1:0] : duty_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      en_q   <= '0;
      duty_q <= '{default: '0};
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      duty_q <= duty_d;
    end
  end
`ifdef LED_PWM_CTRL_BLINK_EN
  logic [7:0] blink_q, blink_d;
  logic [3:0] per_q;
  logic       phase_q;
  always_comb blink_d = write_strobe && ofs == OFS_BLINK ? out_port : blink_q;
  // phase flips on the 16th completed period
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= '0;
      per_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      if (wrap) begin
        per_q <= per_q + 4'd1;
        if (per_q == 4'd15) phase_q <= ~phase_q;
      end
    end
  end
  assign blank = blink_q & {8{phase_q}};
`else
  assign blank = '0;
`endif
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load_i  (wrap),
      .en_i    (en_q[c]),
      .blank_i (blank[c]),
      .shadow_i(duty_q[c]),
      .cnt_i   (cnt_q),
      .led_o   (led[c])
    );
  end
endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00, meaning the first PicoBlaze output port_id decoded by this block.
REQ-002 SHALL have parameter PWM_BITS, default 4, meaning the duty resolution; MAX = 2^PWM_BITS-1.
REQ-003 SHALL have parameter PRESCALE, default 1, meaning clocks per PWM tick (>=1).
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port port_id  input  8  PicoBlaze output port address.
REQ-007 SHALL have port out_port  input  8  PicoBlaze output data.
REQ-008 SHALL have port write_strobe  input  1  one-cycle PicoBlaze write qualifier.
REQ-009 SHALL have port led  output  8  registered LED drive that feeds the board LED pins, led[i] = channel i.

Function
REQ-010 SHALL decode the register map with write_strobe=1: BASE+0 = enable mask; BASE+1..BASE+8 = shadow duty for channels 0..7, using out_port[PWM_BITS-1:0]; all other port_id values are ignored.
REQ-011 SHALL write the addressed shadow register on the clock edge where write_strobe=1; there is no wait or acknowledge.
REQ-012 SHALL take effect immediately for an enable-mask write: led[i] is 0 from the next edge when en[i]=0.
REQ-013 SHALL generate a tick every PRESCALE clocks from a prescale counter 0..PRESCALE-1; a tick is asserted when the counter equals PRESCALE-1, and the counter then wraps to 0.
REQ-014 SHALL advance the period counter cnt on each tick over 0..MAX-1 and wrap it to 0, giving a period of MAX ticks.
REQ-015 SHALL load the active duty registers from the shadow duty registers on the tick where cnt wraps to 0, so duty changes never glitch mid-period.
REQ-016 SHALL use the pre-edge shadow value for that load when a shadow write and the load occur on the same edge; the new value applies one period later.
REQ-017 SHALL register led[i] = en[i] & (cnt < active_duty[i]), so led lags cnt by one clock.
REQ-018 SHALL treat duty boundaries as follows: duty 0 is always off; duty MAX is always on, with no single-tick dropout at the wrap.

Reset
REQ-019 SHALL clear, while rst=1 at an edge: prescale counter, cnt, enable mask, all shadow and active duties, blink state, and led (8'h00).
REQ-020 SHALL apply the same reset mid-period: led is 0 on the edge after rst is sampled, and counting restarts from 0 on the first edge with rst=0.
REQ-021 SHALL let rst take priority over a simultaneous write_strobe; the write is lost.

Configuration
REQ-022 SHALL, when macro LED_PWM_CTRL_BLINK_EN is defined, add register BASE+9 (blink mask) and a blink phase bit that toggles every 16 complete PWM periods; a channel with its blink bit set drives 0 while the phase is 1.
REQ-023 SHALL, when LED_PWM_CTRL_BLINK_EN is undefined, omit the blink logic entirely and treat BASE+9 as unmapped.

Structure
REQ-024 SHALL place the register offset constants (OFS_EN=0, OFS_DUTY0=1, OFS_BLINK=9) and the channel count (8) in the shared package led_pwm_pkg.
REQ-025 SHALL implement each LED's active duty, compare and output flop in sub-module led_pwm_channel, instantiated 8 times; prescaler, cnt and decode stay in led_pwm_ctrl.

Verification
REQ-026 SHALL cover reset: rst=1 for 2 clocks with writes attempted -> led=8'h00, and all registers are 0 after release.
REQ-027 SHALL cover duty ratio (PWM_BITS=4, PRESCALE=1): write EN=8'h01, DUTY0=5 -> after the next wrap, led[0] is high exactly 5 of every 15 clocks.
REQ-028 SHALL cover boundaries: DUTY1=0 -> led[1] never high; DUTY2=15 with EN=8'h06 -> led[2] constantly high across 3 periods.
REQ-029 SHALL cover glitch-free update: write DUTY0 9 -> 3 at cnt=6 -> the current period keeps 9 high ticks and the next period has 3.
REQ-030 SHALL cover a same-edge collision: write DUTY0 on the wrap tick -> the new duty appears only in the second following period; mid-period EN=0 -> led[0] is low the next clock.
REQ-031 SHALL cover PRESCALE=3, DUTY0=15 plus mid-period rst -> period = 45 clocks; led=0 the clock after rst; with LED_PWM_CTRL_BLINK_EN defined, BLINK=8'h01 -> led[0] is off for alternate 16-period spans.
